// File: rtl/uart_mem_cmd_parser_if.sv
// Bus bundle between the UART command parser and its environment:
// UART RX/TX byte streams, CPU run enable, and the debug memory port.
interface uart_mem_cmd_parser_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        enable;
  logic        write_mem_req;
  logic        target_mem_type;
  logic [8:0]  target_addr;
  logic [31:0] uart_rx_data_in;
  logic        rw_flag;
  logic [41:0] mem_tx_data_out;
  logic        mem_tx_data_ready;
  logic        busy;
  logic        rx_dropped;

  // Parser side
  modport master (
    input  rx_byte, rx_valid, tx_ready, enable, mem_tx_data_out, mem_tx_data_ready,
    output tx_byte, tx_valid, write_mem_req, target_mem_type, target_addr,
           uart_rx_data_in, rw_flag, busy, rx_dropped
  );

  // Environment side (UART, CPU control, memories)
  modport slave (
    output rx_byte, rx_valid, tx_ready, enable, mem_tx_data_out, mem_tx_data_ready,
    input  tx_byte, tx_valid, write_mem_req, target_mem_type, target_addr,
           uart_rx_data_in, rw_flag, busy, rx_dropped
  );
endinterface

// File: rtl/uart_mem_cmd_parser.sv
// UART command front-end for the instruction/data memory debug port.
// Assembles RX bytes into read/write frames, issues a single-cycle memory
// request while the CPU is halted, and returns an ACK, an error byte, or
// the 6-byte serialized read response on the TX stream.
module uart_mem_cmd_parser #(
  parameter int         FRAME_TIMEOUT = 1024,
  parameter int         RESP_TIMEOUT  = 16,
  parameter logic [7:0] ACK_BYTE      = 8'hAA,
  parameter logic [7:0] ERR_BYTE      = 8'hEE
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_mem_cmd_parser_if.master  bus
);

  localparam int TMAX = (FRAME_TIMEOUT > RESP_TIMEOUT) ? FRAME_TIMEOUT : RESP_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] FRAME_LIM = TW'(FRAME_TIMEOUT);
  localparam logic [TW-1:0] RESP_LIM  = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, ISSUE, WAIT_RESP, SEND_RESP, SEND_BYTE
  } state_t;

  state_t        state_q, state_d;
  logic          frm_rw_q, frm_rw_d;
  logic          frm_type_q, frm_type_d;
  logic [8:0]    frm_addr_q, frm_addr_d;
  logic [31:0]   frm_data_q, frm_data_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  // Remaining response bytes after byte 0, which goes straight to tx_byte.
  logic [39:0]   resp_q, resp_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_valid_q, tx_valid_d;
  logic          out_rw_q, out_rw_d;
  logic          out_type_q, out_type_d;
  logic [8:0]    out_addr_q, out_addr_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          rx_dropped_q, rx_dropped_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      frm_rw_q     <= 1'b0;
      frm_type_q   <= 1'b0;
      frm_addr_q   <= '0;
      frm_data_q   <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      resp_q       <= '0;
      tx_byte_q    <= '0;
      tx_valid_q   <= 1'b0;
      out_rw_q     <= 1'b0;
      out_type_q   <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      rx_dropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frm_rw_q     <= frm_rw_d;
      frm_type_q   <= frm_type_d;
      frm_addr_q   <= frm_addr_d;
      frm_data_q   <= frm_data_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      resp_q       <= resp_d;
      tx_byte_q    <= tx_byte_d;
      tx_valid_q   <= tx_valid_d;
      out_rw_q     <= out_rw_d;
      out_type_q   <= out_type_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      rx_dropped_q <= rx_dropped_d;
    end
  end

  // Next-state logic: frame assembly, issue, response capture and TX sequencing
  always_comb begin
    state_d      = state_q;
    frm_rw_d     = frm_rw_q;
    frm_type_d   = frm_type_q;
    frm_addr_d   = frm_addr_q;
    frm_data_d   = frm_data_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    resp_d       = resp_q;
    tx_byte_d    = tx_byte_q;
    tx_valid_d   = tx_valid_q;
    out_rw_d     = out_rw_q;
    out_type_d   = out_type_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    rx_dropped_d = rx_dropped_q;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          frm_rw_d      = bus.rx_byte[7];
          frm_type_d    = bus.rx_byte[6];
          frm_addr_d[8] = bus.rx_byte[0];
          timer_d       = '0;
          if (bus.rx_byte[5:1] != 5'd0) begin
            tx_byte_d = ERR_BYTE;
            state_d   = SEND_BYTE;
          end else begin
            state_d   = ADDR;
          end
        end
      end

      ADDR: begin
        if (bus.rx_valid) begin
          frm_addr_d[7:0] = bus.rx_byte;
          timer_d         = '0;
          cnt_d           = '0;
          state_d         = frm_rw_q ? DATA : ISSUE;
        end else if (timer_q >= FRAME_LIM) begin
          state_d = IDLE;
        end else if (timer_q != {TW{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end
      end

      DATA: begin
        if (bus.rx_valid) begin
          frm_data_d = {frm_data_q[23:0], bus.rx_byte};
          timer_d    = '0;
          if (cnt_q == 3'd3) begin
            cnt_d   = '0;
            state_d = ISSUE;
          end else begin
            cnt_d   = cnt_q + 3'd1;
          end
        end else if (timer_q >= FRAME_LIM) begin
          state_d = IDLE;
        end else if (timer_q != {TW{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end
      end

      ISSUE: begin
        timer_d = '0;
        if (bus.enable) begin
          tx_byte_d = ERR_BYTE;
          state_d   = SEND_BYTE;
        end else if (out_rw_q) begin
          tx_byte_d = ACK_BYTE;
          state_d   = SEND_BYTE;
        end else begin
          state_d   = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        // A ready strobe on the expiry cycle still wins over the timeout.
        if (bus.mem_tx_data_ready) begin
          tx_byte_d = {6'b0, bus.mem_tx_data_out[41:40]};
          resp_d    = bus.mem_tx_data_out[39:0];
          cnt_d     = '0;
          state_d   = SEND_RESP;
        end else if (timer_q >= RESP_LIM) begin
          tx_byte_d = ERR_BYTE;
          state_d   = SEND_BYTE;
        end else if (timer_q != {TW{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end
      end

      SEND_RESP: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
        end else if (bus.tx_ready) begin
          if (cnt_q == 3'd5) begin
            tx_valid_d = 1'b0;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            tx_byte_d  = resp_q[39:32];
            resp_d     = {resp_q[31:0], 8'h00};
            cnt_d      = cnt_q + 3'd1;
          end
        end
      end

      SEND_BYTE: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
        end else if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Request fields are refreshed only on entry to ISSUE so they stay
    // stable between accesses.
    if (state_d == ISSUE && state_q != ISSUE) begin
      out_rw_d   = frm_rw_d;
      out_type_d = frm_type_d;
      out_addr_d = frm_addr_d;
      out_data_d = frm_data_d;
    end

    if (bus.rx_valid && (state_q == ISSUE || state_q == WAIT_RESP ||
                         state_q == SEND_RESP || state_q == SEND_BYTE)) begin
      rx_dropped_d = 1'b1;
    end
  end

  assign bus.write_mem_req   = (state_q == ISSUE) && !bus.enable;
  assign bus.target_mem_type = out_type_q;
  assign bus.target_addr     = out_addr_q;
  assign bus.uart_rx_data_in = out_data_q;
  assign bus.rw_flag         = out_rw_q;
  assign bus.tx_byte         = tx_byte_q;
  assign bus.tx_valid        = tx_valid_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.rx_dropped      = rx_dropped_q;

endmodule

// File: doc/uart_mem_cmd_parser.md
Name: uart_mem_cmd_parser

Overview:
- Upstream command front-end for the instruction and data memories' debug port.
- Assembles UART RX bytes into read/write frames and issues single-cycle memory access requests (write_mem_req, target_mem_type, target_addr, uart_rx_data_in, rw_flag).
- For reads, captures the memory's 42-bit response and serializes it to the UART TX byte stream. For writes, returns an ACK byte. Errors return an error byte.
- Accesses are issued only while the CPU is halted (enable=0).

Parameters:
- FRAME_TIMEOUT, 1024: max idle cycles between bytes of one frame before the partial frame is discarded.
- RESP_TIMEOUT, 16: max cycles from a read issue to mem_tx_data_ready before an error byte is returned.
- ACK_BYTE, 8'hAA: byte sent after a successful write.
- ERR_BYTE, 8'hEE: byte sent on any error.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_byte  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe, rx_byte valid.
- tx_byte  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_byte valid. Held until accepted.
- tx_ready  in  1  transmitter accepts tx_byte when tx_valid&&tx_ready.
- enable  in  1  CPU run enable. Accesses are legal only when 0.
- write_mem_req  out  1  one-cycle access request pulse.
- target_mem_type  out  1  1=instruction memory, 0=data memory.
- target_addr  out  9  word address.
- uart_rx_data_in  out  32  write data.
- rw_flag  out  1  1=write, 0=read.
- mem_tx_data_out  in  42  read response {1'b1, addr[8:0], data[31:0]}.
- mem_tx_data_ready  in  1  one-cycle strobe, response valid.
- busy  out  1  high in any state other than IDLE.
- rx_dropped  out  1  sticky: an rx byte arrived outside a receive state. Cleared by reset only.

Behaviour:
- Frame format, MSB first:
  - Header byte: bit7 = rw_flag, bit6 = target_mem_type, bits5:1 reserved (must be 0), bit0 = addr[8].
  - Then addr[7:0].
  - Writes only: then 4 data bytes, data[31:24] first.
- Reset values: tx_byte=0, tx_valid=0, write_mem_req=0, target_mem_type=0, target_addr=0, uart_rx_data_in=0, rw_flag=0, busy=0, rx_dropped=0. State=IDLE, all counters 0.
- FSM states: IDLE, ADDR, DATA, ISSUE, WAIT_RESP, SEND_RESP, SEND_BYTE.
- IDLE:
  - On rx_valid, latch the header.
  - Reserved bits nonzero -> SEND_BYTE with ERR_BYTE.
  - Otherwise -> ADDR.
- ADDR: on rx_valid, latch addr[7:0]. Write -> DATA with byte count 0. Read -> ISSUE.
- DATA: shift in 4 bytes; after the 4th -> ISSUE.
- Inter-byte timeout: in ADDR and DATA, a counter resets on each rx_valid. When it reaches FRAME_TIMEOUT, the frame is discarded silently and the FSM returns to IDLE.
- ISSUE (one cycle):
  - enable=1 -> no request; SEND_BYTE with ERR_BYTE.
  - Otherwise drive write_mem_req=1 for exactly this cycle with target_mem_type, target_addr, rw_flag and uart_rx_data_in valid.
  - These four outputs stay stable until the next ISSUE.
  - Write -> SEND_BYTE with ACK_BYTE. Read -> WAIT_RESP with the timeout counter cleared.
- WAIT_RESP:
  - On mem_tx_data_ready, capture mem_tx_data_out zero-extended to 48 bits -> SEND_RESP.
  - After RESP_TIMEOUT cycles without ready -> SEND_BYTE with ERR_BYTE.
  - A ready strobe arriving in the same cycle as timeout expiry counts as success.
- SEND_RESP:
  - Emit 6 bytes, bits 47:40 first. Byte0 = {6'b0, resp[41:40]}.
  - Advance on each tx_valid&&tx_ready. After the 6th handshake -> IDLE.
- SEND_BYTE: emit one byte. On handshake -> IDLE.
- tx handshake: tx_valid rises the cycle after entering a send state. tx_byte must not change while tx_valid&&!tx_ready. tx_valid drops the cycle after the final handshake.
- rx_valid in ISSUE, WAIT_RESP, SEND_RESP or SEND_BYTE: the byte is ignored and rx_dropped is set.
- A write to an instruction-memory address is visible to a read issued in a later frame; no hazarding is needed inside this block.
- Reset asserted mid-frame or mid-send: the next edge forces reset values, discards all partial state, and abandons any in-flight tx byte.
- Counters saturate and never wrap.

Test Plan:
- Write, enable=0: rx 0xC0,0x05,0xDE,0xAD,0xBE,0xEF -> exactly one write_mem_req pulse with target_mem_type=1, rw_flag=1, target_addr=5, uart_rx_data_in=0xDEADBEEF; then tx 0xAA.
- Read: rx 0x40,0x05; memory model returns 42'h2_05DE_ADBE_EF… i.e. {1,9'h005,32'hDEADBEEF} two cycles after the pulse -> tx bytes 0x02,0x05,0xDE,0xAD,0xBE,0xEF.
- Backpressure: tx_ready held low 10 cycles during the read response -> tx_byte stable while stalled; all 6 bytes delivered in order with none lost or duplicated.
- enable=1 at issue: rx 0x80,0x01,4 data bytes -> no write_mem_req; tx 0xEE.
- Timeouts:
  - Header only, then FRAME_TIMEOUT idle cycles -> return to IDLE, no tx; the next valid frame is processed normally.
  - Read with no ready for 16 cycles -> tx 0xEE.
- Reserved header bits set (0x42) -> tx 0xEE. An rx byte injected during SEND -> rx_dropped=1. Reset mid-DATA -> all outputs at reset values, and a fresh frame then works.
